main_control_fsm: RTL and testbench
===================================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Parameter USE_MEM_READY, default 1: 1 = memory states wait on memReady_i; 0 = memReady_i ignored and treated as 1.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 op_i  input  6  opcode field from the instruction register, stable from DECODE through writeback.
REQ-005 memReady_i  input  1  memory access completes in the current cycle.
REQ-006 pcWrite_o / pcWriteCond_o / irWrite_o / regWrite_o / memRead_o / memWrite_o  output  1 each  datapath strobes.
REQ-007 iorD_o / memToReg_o / regDst_o / aluSrcA_o  output  1 each  datapath mux selects.
REQ-008 aluSrcB_o  output  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm.
REQ-009 pcSrc_o  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 aluOp_o  output  4  to ALU control: 0000 add, 0001 sub, 0010 funct-decoded, 0011 addi, 0100 andi, 0101 ori, 0110 slti.
REQ-011 state_o  output  4  current state encoding.
REQ-012 illegal_o  output  1  one-cycle pulse on an unsupported opcode.
REQ-013 illegalCnt_o  output  8  saturating count of illegal opcodes.

Function
REQ-014 States and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, ILLEGAL 12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-015 Outputs SHALL decode from state only, except the memReady gating in REQ-016 and REQ-019; any strobe or select not listed for a state SHALL be 0.
REQ-016 FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=0000, pcSrc=00, irWrite=pcWrite=memReady; remain in FETCH until memReady, then go to DECODE.
REQ-017 DECODE: aluSrcA=0, aluSrcB=11, aluOp=0000; next state by op_i: 100011 or 101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000/001100/001101/001010 -> IMMEX, 000010 -> JUMP, any other -> ILLEGAL.
REQ-018 MEMADR: aluSrcA=1, aluSrcB=10, aluOp=0000; next is MEMRD for op 100011, otherwise MEMWR.
REQ-019 MEMRD: memRead=1, iorD=1; MEMWR: memWrite=1, iorD=1; each holds until memReady; then MEMRD -> MEMWB and MEMWR -> FETCH.
REQ-020 MEMWB: regDst=0, memToReg=1, regWrite=1 -> FETCH.
REQ-021 EXEC: aluSrcA=1, aluSrcB=00, aluOp=0010 -> RWB; RWB: regDst=1, memToReg=0, regWrite=1 -> FETCH.
REQ-022 BRANCH: aluSrcA=1, aluSrcB=00, aluOp=0001, pcWriteCond=1, pcSrc=01 -> FETCH.
REQ-023 IMMEX: aluSrcA=1, aluSrcB=10, aluOp = 0011/0100/0101/0110 for op 001000/001100/001101/001010 -> IMMWB; IMMWB: regDst=0, memToReg=0, regWrite=1 -> FETCH.
REQ-024 JUMP: pcWrite=1, pcSrc=10 -> FETCH.
REQ-025 ILLEGAL: illegal_o=1 for this single cycle; illegalCnt_o increments by 1 and saturates at 255; next state is FETCH.
REQ-026 Cycle counts with zero wait (FETCH to FETCH inclusive): lw 5, sw 4, R-type 4, addi/andi/ori/slti 4, beq 3, j 3, illegal 3. Each cycle memReady_i is low in FETCH/MEMRD/MEMWR adds exactly one cycle.
REQ-027 memWrite_o and memRead_o SHALL never be 1 in the same cycle.

Reset
REQ-028 While rst_ni is 0, state SHALL be FETCH, illegalCnt_o 0, and every output 0, including the strobes, selects, aluOp_o, state_o and illegal_o.
REQ-029 Reset assertion mid-instruction SHALL abort the instruction immediately; no strobe is emitted after the asynchronous assertion.
REQ-030 On the first rising edge after rst_ni rises, FETCH outputs SHALL be driven.

Structure
REQ-031 A shared package mips_ctrl_pkg SHALL hold the state encodings, the opcode constants and the aluOp constants, for reuse by ALU control and the datapath.
REQ-032 One sub-module, main_control_outdec, SHALL map state plus memReady to the control word combinationally; the FSM and counter remain in main_control_fsm.

Verification
REQ-033 Reset release, memReady=1, op 100011 -> states 0,1,2,3,4,0; regWrite=1 and memToReg=1 only in state 4.
REQ-034 op 101011 with memReady low for 2 cycles in MEMWR -> memWrite=1 for 3 cycles, iorD=1, then FETCH; regWrite never asserted.
REQ-035 op 001101 -> aluOp 0101 in IMMEX, regWrite=1 with regDst=0 in IMMWB; op 000000 -> aluOp 0010, then regDst=1.
REQ-036 op 000100 -> pcWriteCond=1, pcSrc=01, aluOp=0001 for one cycle; op 000010 -> pcWrite=1, pcSrc=10.
REQ-037 300 consecutive op 111111 -> illegal_o pulses 300 times, illegalCnt_o ends at 255.
REQ-038 rst_ni pulled low during MEMRD -> all outputs 0 immediately; after release, FETCH with memRead=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: FSM state codes,
// opcode constants, ALU-op codes, datapath select codes and the packed
// control word that the output decoder produces.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRwb     = 4'd7,
    StBranch  = 4'd8,
    StImmEx   = 4'd9,
    StImmWb   = 4'd10,
    StJump    = 4'd11,
    StIllegal = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;

  localparam logic [3:0] AluOpAdd   = 4'b0000;
  localparam logic [3:0] AluOpSub   = 4'b0001;
  localparam logic [3:0] AluOpFunct = 4'b0010;
  localparam logic [3:0] AluOpAddi  = 4'b0011;
  localparam logic [3:0] AluOpAndi  = 4'b0100;
  localparam logic [3:0] AluOpOri   = 4'b0101;
  localparam logic [3:0] AluOpSlti  = 4'b0110;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // ALU operation for the I-type arithmetic/logic group.
  function automatic logic [3:0] imm_alu_op(logic [5:0] op);
    logic [3:0] res;
    res = AluOpAdd;
    case (op)
      OpAddi:  res = AluOpAddi;
      OpAndi:  res = AluOpAndi;
      OpOri:   res = AluOpOri;
      OpSlti:  res = AluOpSlti;
      default: res = AluOpAdd;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/main_control_outdec.sv
// Combinational control-word decoder for the main control FSM.
// Ports:
//   state_i     current FSM state code
//   mem_ready_i memory handshake (gates IR/PC write in FETCH)
//   op_i        opcode, selects the ALU op in IMMEX
//   ctrl_o      full datapath control word
module main_control_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  input  logic [5:0] op_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SrcBFour;
        ctrl_o.alu_op    = AluOpAdd;
        ctrl_o.pc_src    = PcSrcAlu;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      StDecode: begin
        ctrl_o.alu_src_b = SrcBImmSh;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemAdr: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemRd: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      StMemWr: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      StExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBReg;
        ctrl_o.alu_op    = AluOpFunct;
      end
      StRwb: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SrcBReg;
        ctrl_o.alu_op        = AluOpSub;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PcSrcAluOut;
      end
      StImmEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = imm_alu_op(op_i);
      end
      StImmWb: begin
        ctrl_o.reg_write = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PcSrcJump;
      end
      StIllegal: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control FSM with illegal-opcode counter.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   op_i                     instruction opcode
//   memReady_i               memory access completes this cycle
//   pcWrite_o .. memWrite_o  datapath strobes
//   iorD_o .. aluSrcA_o      datapath mux selects
//   aluSrcB_o, pcSrc_o       2-bit selects
//   aluOp_o                  ALU control operation
//   state_o                  current state code
//   illegal_o, illegalCnt_o  illegal-opcode pulse and saturating count
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] op_i,
  input  logic       memReady_i,
  output logic       pcWrite_o,
  output logic       pcWriteCond_o,
  output logic       irWrite_o,
  output logic       regWrite_o,
  output logic       memRead_o,
  output logic       memWrite_o,
  output logic       iorD_o,
  output logic       memToReg_o,
  output logic       regDst_o,
  output logic       aluSrcA_o,
  output logic [1:0] aluSrcB_o,
  output logic [1:0] pcSrc_o,
  output logic [3:0] aluOp_o,
  output logic [3:0] state_o,
  output logic       illegal_o,
  output logic [7:0] illegalCnt_o
);

  state_e     state_q, state_d;
  logic       active_q;
  logic [7:0] cnt_q;
  logic       mem_ready;
  ctrl_t      ctrl_raw, ctrl;

  assign mem_ready = USE_MEM_READY ? memReady_i : 1'b1;

  // active_q holds every output at zero until the first edge after reset
  // release, so FETCH begins cleanly on that edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StFetch;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      if (state_q == StIllegal && cnt_q != 8'hff) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = StFetch;
    if (active_q) begin
      case (state_q)
        StFetch:  state_d = mem_ready ? StDecode : StFetch;
        StDecode: begin
          case (op_i)
            OpLw, OpSw:                    state_d = StMemAdr;
            OpRtype:                       state_d = StExec;
            OpBeq:                         state_d = StBranch;
            OpAddi, OpAndi, OpOri, OpSlti: state_d = StImmEx;
            OpJ:                           state_d = StJump;
            default:                       state_d = StIllegal;
          endcase
        end
        StMemAdr: state_d = (op_i == OpLw) ? StMemRd : StMemWr;
        StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
        StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
        StExec:   state_d = StRwb;
        StImmEx:  state_d = StImmWb;
        default:  state_d = StFetch;
      endcase
    end
  end

  main_control_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .op_i        (op_i),
    .ctrl_o      (ctrl_raw)
  );

  assign ctrl = active_q ? ctrl_raw : '0;

  assign pcWrite_o     = ctrl.pc_write;
  assign pcWriteCond_o = ctrl.pc_write_cond;
  assign irWrite_o     = ctrl.ir_write;
  assign regWrite_o    = ctrl.reg_write;
  assign memRead_o     = ctrl.mem_read;
  assign memWrite_o    = ctrl.mem_write;
  assign iorD_o        = ctrl.iord;
  assign memToReg_o    = ctrl.mem_to_reg;
  assign regDst_o      = ctrl.reg_dst;
  assign aluSrcA_o     = ctrl.alu_src_a;
  assign aluSrcB_o     = ctrl.alu_src_b;
  assign pcSrc_o       = ctrl.pc_src;
  assign aluOp_o       = ctrl.alu_op;
  assign illegal_o     = ctrl.illegal;
  assign state_o       = state_q;
  assign illegalCnt_o  = cnt_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: table vectors, randomized
// instruction stream, reset corner cases and illegal-count saturation.
module tb_main_control_fsm;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [5:0] op_i;
  logic       memReady_i;
  logic       pcWrite_o, pcWriteCond_o, irWrite_o, regWrite_o, memRead_o, memWrite_o;
  logic       iorD_o, memToReg_o, regDst_o, aluSrcA_o;
  logic [1:0] aluSrcB_o, pcSrc_o;
  logic [3:0] aluOp_o, state_o;
  logic       illegal_o;
  logic [7:0] illegalCnt_o;

  always #5 clk_i = ~clk_i;

  main_control_fsm #(.USE_MEM_READY(1'b1)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .op_i          (op_i),
    .memReady_i    (memReady_i),
    .pcWrite_o     (pcWrite_o),
    .pcWriteCond_o (pcWriteCond_o),
    .irWrite_o     (irWrite_o),
    .regWrite_o    (regWrite_o),
    .memRead_o     (memRead_o),
    .memWrite_o    (memWrite_o),
    .iorD_o        (iorD_o),
    .memToReg_o    (memToReg_o),
    .regDst_o      (regDst_o),
    .aluSrcA_o     (aluSrcA_o),
    .aluSrcB_o     (aluSrcB_o),
    .pcSrc_o       (pcSrc_o),
    .aluOp_o       (aluOp_o),
    .state_o       (state_o),
    .illegal_o     (illegal_o),
    .illegalCnt_o  (illegalCnt_o)
  );

  logic [18:0] act_ctrl;
  assign act_ctrl = {pcWrite_o, pcWriteCond_o, irWrite_o, regWrite_o, memRead_o, memWrite_o,
                     iorD_o, memToReg_o, regDst_o, aluSrcA_o, aluSrcB_o, pcSrc_o, aluOp_o,
                     illegal_o};

  int n_tests = 0;
  int n_fail = 0;
  int ill_model = 0;
  int ill_pulses = 0;
  int exp_st_q[$];
  bit rdy_q[$];

  typedef struct {
    string      name;
    logic [5:0] op;
    int         fw;
    int         mw;
    int         cycles;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mem(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011;
  endfunction

  function automatic bit is_imm(input logic [5:0] op);
    return op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001010;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return is_mem(op) || is_imm(op) || op == 6'b000000 || op == 6'b000100 || op == 6'b000010;
  endfunction

  // Zero-wait instruction length, FETCH through last state.
  function automatic int base_cycles(input logic [5:0] op);
    if (op == 6'b100011) return 5;
    if (op == 6'b101011 || op == 6'b000000 || is_imm(op)) return 4;
    return 3;
  endfunction

  // Expected control word {strobes, selects, aluOp, illegal} for a state.
  function automatic logic [18:0] model_ctrl(input int st, input bit rdy, input logic [5:0] op);
    logic pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, ill;
    logic [1:0] asb, pcs;
    logic [3:0] aop;
    {pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 4'b0000;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 4'b0010; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 4'b0001; pwc = 1; pcs = 2'b01; end
      9:  begin
        asa = 1; asb = 2'b10;
        if (op == 6'b001000) aop = 4'b0011;
        else if (op == 6'b001100) aop = 4'b0100;
        else if (op == 6'b001101) aop = 4'b0101;
        else if (op == 6'b001010) aop = 4'b0110;
      end
      10: rw = 1;
      11: begin pw = 1; pcs = 2'b10; end
      12: ill = 1;
      default: ;
    endcase
    return {pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, asb, pcs, aop, ill};
  endfunction

  task automatic push(input int st, input bit rdy);
    exp_st_q.push_back(st);
    rdy_q.push_back(rdy);
  endtask

  // Expected state walk for one instruction, with fw FETCH waits and mw
  // waits in the memory-access state.
  task automatic build_seq(input logic [5:0] op, input int fw, input int mw);
    exp_st_q.delete();
    rdy_q.delete();
    repeat (fw) push(0, 0);
    push(0, 1);
    push(1, 1);
    if (op == 6'b100011) begin
      push(2, 1); repeat (mw) push(3, 0); push(3, 1); push(4, 1);
    end else if (op == 6'b101011) begin
      push(2, 1); repeat (mw) push(5, 0); push(5, 1);
    end else if (op == 6'b000000) begin
      push(6, 1); push(7, 1);
    end else if (op == 6'b000100) push(8, 1);
    else if (is_imm(op)) begin
      push(9, 1); push(10, 1);
    end else if (op == 6'b000010) push(11, 1);
    else push(12, 1);
  endtask

  // Starts at a negedge with the DUT in FETCH; ends at a negedge back in FETCH.
  task automatic run_instr(input string name, input logic [5:0] op, input int fw, input int mw,
                           input int exp_cycles);
    int cyc;
    bit left;
    bit done;
    logic [3:0] es;
    build_seq(op, fw, mw);
    op_i = op;
    cyc = 0; left = 0; done = 0;
    while (!done && cyc < 40) begin
      memReady_i = (cyc < rdy_q.size()) ? rdy_q[cyc] : 1'b1;
      #1;
      if (illegal_o) ill_pulses++;
      if (cyc < exp_st_q.size()) begin
        es = 4'(exp_st_q[cyc]);
        check({name, " cycle"}, 32'({state_o, act_ctrl}),
              32'({es, model_ctrl(exp_st_q[cyc], rdy_q[cyc], op)}));
      end
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
      if (state_o != 4'd0) left = 1;
      if (left && state_o == 4'd0) done = 1;
    end
    check({name, " cycles"}, 32'(cyc), 32'(exp_cycles));
    if (!is_legal(op)) ill_model++;
    check({name, " illegalCnt"}, 32'(illegalCnt_o), 32'(ill_model > 255 ? 255 : ill_model));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    ill_model = 0;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    logic [5:0] ops[9];
    logic [5:0] op;
    int fw, mw, p0;

    vecs[0]  = '{"lw",        6'b100011, 0, 0, 5};
    vecs[1]  = '{"sw_wait2",  6'b101011, 0, 2, 6};
    vecs[2]  = '{"ori",       6'b001101, 0, 0, 4};
    vecs[3]  = '{"rtype",     6'b000000, 0, 0, 4};
    vecs[4]  = '{"beq",       6'b000100, 0, 0, 3};
    vecs[5]  = '{"j",         6'b000010, 0, 0, 3};
    vecs[6]  = '{"addi_fw1",  6'b001000, 1, 0, 5};
    vecs[7]  = '{"lw_fw1mw1", 6'b100011, 1, 1, 7};
    vecs[8]  = '{"illegal",   6'b111111, 0, 0, 3};
    vecs[9]  = '{"slti",      6'b001010, 0, 0, 4};
    vecs[10] = '{"andi_fw2",  6'b001100, 2, 0, 6};
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
            6'b001000, 6'b001100, 6'b001101, 6'b001010};

    // Reset state: everything zero, even with memReady high.
    rst_ni = 1'b0; op_i = 6'b100011; memReady_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    check("reset outputs", 32'({state_o, act_ctrl, illegalCnt_o}), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("pre-edge idle", 32'({state_o, act_ctrl}), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);

    foreach (vecs[i]) run_instr(vecs[i].name, vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].cycles);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 8)];
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      run_instr("random", op, fw, mw, base_cycles(op) + fw + (is_mem(op) ? mw : 0));
    end

    // Reset asserted mid-MEMRD aborts at once.
    op_i = 6'b100011; memReady_i = 1'b1;
    repeat (3) @(negedge clk_i);
    memReady_i = 1'b0;
    #1;
    check("in memrd", 32'(state_o), 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("abort outputs", 32'({state_o, act_ctrl, illegalCnt_o}), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    ill_model = 0;
    memReady_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("fetch after release", 32'({state_o, act_ctrl}), 32'({4'd0, model_ctrl(0, 1, op_i)}));
    run_instr("lw after reset", 6'b100011, 0, 0, 5);

    // Saturation of the illegal counter.
    do_reset();
    p0 = ill_pulses;
    for (int k = 0; k < 300; k++) run_instr("illegal burst", 6'b111111, 0, 0, 3);
    check("illegal pulses", 32'(ill_pulses - p0), 32'd300);
    check("illegalCnt sat", 32'(illegalCnt_o), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
